// File: rtl/lcd_pkg.sv
// Shared LCD package: panel ID constants, strap codes, detection FSM states.
package lcd_pkg;

    localparam logic [15:0] LCD_ID_4342 = 16'h4342;
    localparam logic [15:0] LCD_ID_7084 = 16'h7084;
    localparam logic [15:0] LCD_ID_7016 = 16'h7016;
    localparam logic [15:0] LCD_ID_4384 = 16'h4384;
    localparam logic [15:0] LCD_ID_1018 = 16'h1018;

    // Strap code is {B7,G7,R7}
    localparam logic [2:0] STRAP_000 = 3'b000;
    localparam logic [2:0] STRAP_001 = 3'b001;
    localparam logic [2:0] STRAP_010 = 3'b010;
    localparam logic [2:0] STRAP_100 = 3'b100;
    localparam logic [2:0] STRAP_101 = 3'b101;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        SAMPLE = 2'd1,
        DONE   = 2'd2,
        FAIL   = 2'd3
    } lcd_state_t;

    // Returns {known, id}; unknown codes give {0, 16'h0000}
    function automatic logic [16:0] lcd_decode(input logic [2:0] code);
        logic [16:0] r;
        case (code)
            STRAP_000: r = {1'b1, LCD_ID_4342};
            STRAP_001: r = {1'b1, LCD_ID_7084};
            STRAP_010: r = {1'b1, LCD_ID_7016};
            STRAP_100: r = {1'b1, LCD_ID_4384};
            STRAP_101: r = {1'b1, LCD_ID_1018};
            default:   r = 17'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lcd_id_sync.sv
// Parameterised-width two-flop synchroniser, asynchronous reset to 0.
module lcd_id_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Two back-to-back flops per bit to resolve metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/lcd_id_reader.sv
// Power-up panel detection: release RGB bus, settle, sample and debounce the
// ID straps {B7,G7,R7}, then decode to lcd_id (or flag an error).
module lcd_id_reader
    import lcd_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1000,
    parameter int SAMPLE_COUNT  = 8,
    parameter int SAMPLE_GAP    = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rescan,
    input  logic [23:0] lcd_rgb_in,
    output logic        lcd_rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_error
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(SAMPLE_COUNT + 1);
    localparam int GW = $clog2(SAMPLE_GAP + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_LAST  = CW'(SAMPLE_COUNT - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(SAMPLE_GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

    logic [2:0]  strap_raw;
    logic [2:0]  strap_sync;
    logic        unused_rgb;

    lcd_state_t  state_reg, state_next;
    logic [SW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [CW-1:0] sample_cnt_reg, sample_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic [RW-1:0] retry_cnt_reg, retry_cnt_next;
    logic [2:0]    ref_code_reg, ref_code_next;

    logic [15:0] lcd_id_reg, lcd_id_next;
    logic        id_valid_reg, id_valid_next;
    logic        id_error_reg, id_error_next;
    logic        oe_reg, oe_next;
    logic [16:0] ref_decoded;

    assign strap_raw  = {lcd_rgb_in[7], lcd_rgb_in[15], lcd_rgb_in[23]};
    // Remaining pad bits carry pixel data, not straps
    assign unused_rgb = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

    lcd_id_sync #(.WIDTH(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (strap_raw),
        .q     (strap_sync)
    );

    assign ref_decoded = lcd_decode(ref_code_reg);

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SETTLE;
            settle_cnt_reg <= '0;
            sample_cnt_reg <= '0;
            gap_cnt_reg    <= '0;
            retry_cnt_reg  <= '0;
            ref_code_reg   <= '0;
            lcd_id_reg     <= '0;
            id_valid_reg   <= 1'b0;
            id_error_reg   <= 1'b0;
            oe_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            sample_cnt_reg <= sample_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            retry_cnt_reg  <= retry_cnt_next;
            ref_code_reg   <= ref_code_next;
            lcd_id_reg     <= lcd_id_next;
            id_valid_reg   <= id_valid_next;
            id_error_reg   <= id_error_next;
            oe_reg         <= oe_next;
        end
    end

    // Next-state, counter and output logic; outputs follow the state one cycle
    // later, except that a rescan clears them on the same edge it leaves DONE/FAIL
    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        sample_cnt_next = sample_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        retry_cnt_next  = retry_cnt_reg;
        ref_code_next   = ref_code_reg;
        lcd_id_next     = 16'h0000;
        id_valid_next   = 1'b0;
        id_error_next   = 1'b0;
        oe_next         = 1'b0;

        case (state_reg)
            SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    state_next      = SAMPLE;
                    settle_cnt_next = '0;
                    sample_cnt_next = '0;
                    gap_cnt_next    = '0;
                end else begin
                    settle_cnt_next = settle_cnt_reg + 1'b1;
                end
            end
            SAMPLE: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    if (sample_cnt_reg == '0) begin
                        ref_code_next   = strap_sync;
                        sample_cnt_next = sample_cnt_reg + 1'b1;
                    end else if (strap_sync != ref_code_reg) begin
                        if (retry_cnt_reg < RETRY_MAX) begin
                            retry_cnt_next  = retry_cnt_reg + 1'b1;
                            settle_cnt_next = '0;
                            state_next      = SETTLE;
                        end else begin
                            state_next = FAIL;
                        end
                    end else if (sample_cnt_reg == COUNT_LAST) begin
                        // Unknown codes are a definite answer; retrying cannot help
                        state_next = ref_decoded[16] ? DONE : FAIL;
                    end else begin
                        sample_cnt_next = sample_cnt_reg + 1'b1;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            DONE: begin
                if (rescan) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                    retry_cnt_next  = '0;
                end else begin
                    lcd_id_next   = ref_decoded[15:0];
                    id_valid_next = 1'b1;
                    oe_next       = 1'b1;
                end
            end
            FAIL: begin
                if (rescan) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                    retry_cnt_next  = '0;
                end else begin
                    id_error_next = 1'b1;
                    oe_next       = 1'b1;
                end
            end
            default: state_next = SETTLE;
        endcase
    end

    assign lcd_rgb_oe = oe_reg;
    assign lcd_id     = lcd_id_reg;
    assign id_valid   = id_valid_reg;
    assign id_error   = id_error_reg;

endmodule

// File: tb/tb_lcd_id_reader.sv
// Directed-plus-random bench for lcd_id_reader against a latency/decode model.
module tb_lcd_id_reader;

    localparam int S = 8;
    localparam int C = 4;
    localparam int G = 2;
    localparam int R = 2;
    localparam int CLEAN_LAT = S + C * G + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rescan;
    logic [23:0] lcd_rgb_in;
    logic        lcd_rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_error;

    int tests = 0;
    int fails = 0;

    lcd_id_reader #(
        .SETTLE_CYCLES (S),
        .SAMPLE_COUNT  (C),
        .SAMPLE_GAP    (G),
        .MAX_RETRY     (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rescan     (rescan),
        .lcd_rgb_in (lcd_rgb_in),
        .lcd_rgb_oe (lcd_rgb_oe),
        .lcd_id     (lcd_id),
        .id_valid   (id_valid),
        .id_error   (id_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strap code {B7,G7,R7} onto pads rgb[7], rgb[15], rgb[23]; other bits random
    function automatic logic [23:0] pads(input logic [2:0] c);
        logic [23:0] v;
        v = 24'($urandom);
        v[7]  = c[2];
        v[15] = c[1];
        v[23] = c[0];
        return v;
    endfunction

    function automatic logic [16:0] ref_id(input logic [2:0] c);
        case (c)
            3'b000:  return {1'b1, 16'h4342};
            3'b001:  return {1'b1, 16'h7084};
            3'b010:  return {1'b1, 16'h7016};
            3'b100:  return {1'b1, 16'h4384};
            3'b101:  return {1'b1, 16'h1018};
            default: return 17'd0;
        endcase
    endfunction

    task automatic chk_outs(input string tag, input logic [15:0] id, input logic v,
                            input logic e, input logic oe);
        chk({tag, "_id"}, 32'(lcd_id), 32'(id));
        chk({tag, "_valid"}, 32'(id_valid), 32'(v));
        chk({tag, "_error"}, 32'(id_error), 32'(e));
        chk({tag, "_oe"}, 32'(lcd_rgb_oe), 32'(oe));
    endtask

    // Counts edges until a result appears; mode 1 toggles 100/101 every G cycles,
    // mode 2 glitches the strap so sample k mismatches, mode 3 pulses rescan after edge k
    task automatic run(input string tag, input int mode, input logic [2:0] code,
                       input int k, output int n);
        bit oe_bad;
        int e;
        oe_bad = 0;
        n = 0;
        e = S + (k + 1) * G;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (id_valid || id_error) break;
            if (lcd_rgb_oe !== 1'b0) oe_bad = 1;
            if (mode == 1) lcd_rgb_in = pads(((n / G) % 2) != 0 ? 3'b101 : 3'b100);
            if (mode == 2 && n == e - 3) lcd_rgb_in = pads(code ^ 3'b001);
            if (mode == 2 && n == e - 2) lcd_rgb_in = pads(code);
            if (mode == 3 && n == k) rescan = 1'b1;
            if (mode == 3 && n == k + 1) rescan = 1'b0;
        end
        if (!(id_valid || id_error)) n = -1;
        chk({tag, "_oe_low_before"}, 32'(oe_bad), 32'd0);
    endtask

    task automatic do_rescan(input string tag);
        @(negedge clk);
        rescan = 1'b1;
        @(posedge clk);
        #1;
        rescan = 1'b0;
        chk_outs({tag, "_cleared"}, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int k;
        int j;
        logic [2:0] tmp;
        logic [2:0] code;
        logic [2:0] codes [5];
        logic [2:0] bad [3];
        logic [16:0] expv;

        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bad   = '{3'b011, 3'b110, 3'b111};

        rst_n      = 1'b0;
        rescan     = 1'b0;
        lcd_rgb_in = pads(3'b001);
        #12;
        chk_outs("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Strap 001 from reset
        @(negedge clk);
        rst_n = 1'b1;
        run("boot", 0, 3'b001, 0, n);
        chk("boot_latency", 32'(n), 32'(CLEAN_LAT));
        chk_outs("boot", 16'h7084, 1'b1, 1'b0, 1'b1);
        $display("[TB] boot strap=001 latency=%0d id=%h", n, lcd_id);

        // All legal codes in random order
        for (int i = 4; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = codes[i];
            codes[i] = codes[j];
            codes[j] = tmp;
        end
        for (int i = 0; i < 5; i++) begin
            code = codes[i];
            expv = ref_id(code);
            lcd_rgb_in = pads(code);
            do_rescan("legal");
            run("legal", 0, code, 0, n);
            chk("legal_latency", 32'(n), 32'(CLEAN_LAT));
            chk_outs("legal", expv[15:0], 1'b1, 1'b0, 1'b1);
            $display("[TB] legal strap=%b latency=%0d id=%h", code, n, lcd_id);
        end

        // Unknown codes: 111 then one random unknown; fail with no retry
        for (int i = 0; i < 2; i++) begin
            code = (i == 0) ? 3'b111 : bad[$urandom_range(2, 0)];
            lcd_rgb_in = pads(code);
            do_rescan("unknown");
            run("unknown", 0, code, 0, n);
            chk("unknown_latency", 32'(n), 32'(CLEAN_LAT));
            chk_outs("unknown", 16'h0000, 1'b0, 1'b1, 1'b1);
            $display("[TB] unknown strap=%b latency=%0d error=%b", code, n, id_error);
        end

        // Unstable strap: each pass mismatches at sample 1, R retries then fail
        lcd_rgb_in = pads(3'b100);
        do_rescan("toggle");
        run("toggle", 1, 3'b100, 0, n);
        chk("toggle_latency", 32'(n), 32'((R + 1) * (S + 2 * G) + 1));
        chk_outs("toggle", 16'h0000, 1'b0, 1'b1, 1'b1);
        $display("[TB] toggle latency=%0d error=%b", n, id_error);

        // One glitch at random sample k of pass 1, then stable 010
        k = $urandom_range(C - 1, 1);
        lcd_rgb_in = pads(3'b010);
        do_rescan("glitch");
        run("glitch", 2, 3'b010, k, n);
        chk("glitch_latency", 32'(n), 32'(S + (k + 1) * G + CLEAN_LAT));
        chk_outs("glitch", 16'h7016, 1'b1, 1'b0, 1'b1);
        $display("[TB] glitch k=%0d latency=%0d id=%h", k, n, lcd_id);

        // rescan during SAMPLE is ignored
        k = $urandom_range(S + C * G - 1, S);
        code = codes[$urandom_range(4, 0)];
        expv = ref_id(code);
        lcd_rgb_in = pads(code);
        do_rescan("rescan_ign");
        run("rescan_ign", 3, code, k, n);
        chk("rescan_ign_latency", 32'(n), 32'(CLEAN_LAT));
        chk_outs("rescan_ign", expv[15:0], 1'b1, 1'b0, 1'b1);
        $display("[TB] rescan at edge %0d ignored latency=%0d id=%h", k + 1, n, lcd_id);

        // Asynchronous reset while DONE clears outputs at once, then full latency
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_done", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run("rst_done_rerun", 0, code, 0, n);
        chk("rst_done_latency", 32'(n), 32'(CLEAN_LAT));
        chk_outs("rst_done_rerun", expv[15:0], 1'b1, 1'b0, 1'b1);
        $display("[TB] reset in DONE rerun latency=%0d id=%h", n, lcd_id);

        // Reset mid-SAMPLE restarts from SETTLE
        code = codes[$urandom_range(4, 0)];
        expv = ref_id(code);
        lcd_rgb_in = pads(code);
        do_rescan("rst_sample");
        repeat (S + 3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs("rst_sample", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run("rst_sample_rerun", 0, code, 0, n);
        chk("rst_sample_latency", 32'(n), 32'(CLEAN_LAT));
        chk_outs("rst_sample_rerun", expv[15:0], 1'b1, 1'b0, 1'b1);
        $display("[TB] reset mid-SAMPLE strap=%b latency=%0d id=%h", code, n, lcd_id);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
